// File: rtl/axis_pattern_source.sv
// AXI4-Stream packet generator feeding the DMA S2MM channel.
// Emits pkt_count packets of pkt_len beats with counter, constant or LFSR payload.
module axis_pattern_source #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      pkt_len,
  input  logic [15:0]           pkt_count,
  input  logic [7:0]            gap_len,
  input  logic [1:0]            mode,
  input  logic [31:0]           seed,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           beats_sent
);

  localparam int unsigned KEEP_W    = DATA_W / 8;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [15:0]       count_q;
  logic [7:0]        gap_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] seed_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic [15:0]       pkt_idx;
  logic [7:0]        gap_cnt;

  logic              fire_c;
  logic              last_pkt_c;
  logic              next_last_c;
  logic              single_beat_c;
  logic [DATA_W-1:0] next_data_c;

  // Galois LFSR, right shift; taps applied when the bit shifted out is 1
  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] v);
    lfsr_step = v[0] ? ((v >> 1) ^ DATA_W'(LFSR_TAPS)) : (v >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] first_data(input logic [1:0]  md,
                                                   input logic [31:0] sd);
    if (md == MODE_LFSR && sd == 32'd0) first_data = DATA_W'(1);
    else                                first_data = DATA_W'(sd);
  endfunction

  // Next payload derives from the beat currently held in tdata, which stays
  // put through gaps so counter and LFSR sequences continue across packets.
  always_comb begin
    fire_c        = m_axis_tvalid & m_axis_tready;
    last_pkt_c    = (pkt_idx + 16'd1) == count_q;
    next_last_c   = (beat_cnt + LEN_W'(1)) == (len_q - LEN_W'(1));
    single_beat_c = len_q == LEN_W'(1);
    case (mode_q)
      MODE_CONST: next_data_c = seed_q;
      MODE_LFSR:  next_data_c = lfsr_step(m_axis_tdata);
      default:    next_data_c = m_axis_tdata + DATA_W'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      len_q         <= '0;
      count_q       <= '0;
      gap_q         <= '0;
      mode_q        <= '0;
      seed_q        <= '0;
      beat_cnt      <= '0;
      pkt_idx       <= '0;
      gap_cnt       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      beats_sent    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q      <= pkt_len;
            count_q    <= pkt_count;
            gap_q      <= gap_len;
            mode_q     <= mode;
            seed_q     <= DATA_W'(seed);
            beat_cnt   <= '0;
            pkt_idx    <= '0;
            beats_sent <= '0;
            if (pkt_len == '0 || pkt_count == 16'd0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state         <= SEND;
              busy          <= 1'b1;
              m_axis_tvalid <= 1'b1;
              m_axis_tkeep  <= {KEEP_W{1'b1}};
              m_axis_tdata  <= first_data(mode, seed);
              m_axis_tlast  <= pkt_len == LEN_W'(1);
            end
          end
        end

        SEND: begin
          if (fire_c) begin
            beats_sent <= beats_sent + 32'd1;
            if (m_axis_tlast) begin
              pkt_idx  <= pkt_idx + 16'd1;
              beat_cnt <= '0;
              if (last_pkt_c) begin
                state         <= FIN;
                busy          <= 1'b0;
                done          <= 1'b1;
                m_axis_tvalid <= 1'b0;
                m_axis_tkeep  <= '0;
                m_axis_tlast  <= 1'b0;
              end else if (gap_q == 8'd0) begin
                m_axis_tdata <= next_data_c;
                m_axis_tlast <= single_beat_c;
              end else begin
                state         <= GAP;
                gap_cnt       <= gap_q;
                m_axis_tvalid <= 1'b0;
                m_axis_tkeep  <= '0;
                m_axis_tlast  <= 1'b0;
              end
            end else begin
              beat_cnt     <= beat_cnt + LEN_W'(1);
              m_axis_tdata <= next_data_c;
              m_axis_tlast <= next_last_c;
            end
          end
        end

        // gap_cnt starts at gap_len so tvalid is low for exactly gap_len cycles
        GAP: begin
          if (gap_cnt == 8'd1) begin
            state         <= SEND;
            m_axis_tvalid <= 1'b1;
            m_axis_tkeep  <= {KEEP_W{1'b1}};
            m_axis_tdata  <= next_data_c;
            m_axis_tlast  <= single_beat_c;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
